// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: default frame size, complex sample type
// and the bit-reversal helper used for reorder addressing.
package fft_pkg;

    localparam int N_LOG2_DEF = 4;
    localparam int CPLX_W     = 17;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Reverse the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        v = idx;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port reorder RAM: one write port, one registered read port.
module fft_reorder_ram
    import fft_pkg::*;
#(
    parameter int DW = 34,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed input frames, reads them out
// in natural order as gap-free N-cycle bursts with sop/eop markers.
//
// state   | meaning
// S_IDLE  | no filled bank pending, outputs idle
// S_BURST | issuing reads rd_idx = 0..N-1 from rd_bank, one per cycle
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int W      = 17,
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                valid_out,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                sop_out,
    output logic                eop_out
);

    localparam int AW = N_LOG2 + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state;
    logic [N_LOG2-1:0] wr_idx;
    logic              wr_bank;
    logic [N_LOG2-1:0] rd_idx;
    logic              rd_bank;

    logic              frame_done;
    logic              last_rd;
    logic              rd_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [2*W-1:0]    rd_data;

    logic              rd_vld;
    logic              rd_sop;
    logic              rd_eop;

    assign frame_done = valid_in && (wr_idx == '1);
    assign last_rd    = (state == S_BURST) && (rd_idx == '1);
    assign rd_en      = (state == S_BURST);
    assign wr_addr    = {wr_bank, N_LOG2'(bitrev(32'(wr_idx), N_LOG2))};
    assign rd_addr    = {rd_bank, rd_idx};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (valid_in) begin
            wr_idx <= wr_idx + 1'b1;
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // A frame completing on the last read chains straight into the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_done) begin
                        state   <= S_BURST;
                        rd_bank <= wr_bank;
                        rd_idx  <= '0;
                    end
                end
                S_BURST: begin
                    rd_idx <= rd_idx + 1'b1;
                    if (last_rd) begin
                        if (frame_done) begin
                            rd_bank <= wr_bank;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fft_reorder_ram #(
        .DW (2*W),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (valid_in),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Markers travel alongside the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_sop <= 1'b0;
            rd_eop <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            rd_sop <= rd_en && (rd_idx == '0);
            rd_eop <= last_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            valid_out <= rd_vld;
            sop_out   <= rd_sop;
            eop_out   <= rd_eop;
            if (rd_vld) begin
                out_re <= rd_data[2*W-1:W];
                out_im <= rd_data[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-level reference model undoing the
// bit-reversed permutation, with latency, contiguity and reset checks.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int W = 17;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid_in = 1'b0;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                valid_out;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                sop_out;
    logic                eop_out;

    typedef struct {
        cplx_t d;
        bit    sop;
        bit    eop;
    } exp_t;

    exp_t  exp_q[$];
    cplx_t acc[$];
    int    lat_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    int run = 0;
    int max_run = 0;
    bit in_burst = 1'b0;

    fft_bitrev_reorder #(
        .W      (W),
        .N_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_re     (in_re),
        .in_im     (in_im),
        .valid_out (valid_out),
        .out_re    (out_re),
        .out_im    (out_im),
        .sop_out   (sop_out),
        .eop_out   (eop_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, expv, edge_cnt);
    endtask

    function automatic int rev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r += (1 << (3 - b));
        end
        return r;
    endfunction

    // Model: a complete frame in arrival order is emitted with out[n] = in[rev(n)].
    task automatic model_push(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        cplx_t c;
        exp_t  e;
        c.re = re;
        c.im = im;
        acc.push_back(c);
        if (acc.size() == N) begin
            for (int n = 0; n < N; n++) begin
                e.d   = acc[rev(n)];
                e.sop = (n == 0);
                e.eop = (n == N - 1);
                exp_q.push_back(e);
            end
            lat_q.push_back(edge_cnt + 1);
            acc.delete();
        end
    endtask

    task automatic drive_sample(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        @(negedge clk);
        valid_in = 1'b1;
        in_re    = re;
        in_im    = im;
        @(posedge clk);
        model_push(re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic stop();
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // mode 0: re = rev(k)+off, im = -re; mode 1: full-scale alternation; mode 2: random.
    // gap < 0 selects a random 0..2 idle cycles after each sample.
    task automatic send_frame(input int mode, input int off, input int gap, input int count);
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        int g;
        for (int k = 0; k < count; k++) begin
            case (mode)
                0: begin
                    re = W'(rev(k) + off);
                    im = W'(-(rev(k) + off));
                end
                1: begin
                    re = (k % 2 == 1) ? W'(65535) : W'(-65536);
                    im = (k % 2 == 1) ? W'(-65536) : W'(65535);
                end
                default: begin
                    re = W'($urandom);
                    im = W'($urandom);
                end
            endcase
            drive_sample(re, im);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (g > 0) idle(g);
        end
    endtask

    // Called on a falling edge; model is flushed at the reset edge.
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        acc.delete();
        exp_q.delete();
        lat_q.delete();
        in_burst = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_re"}, out_re, 0);
        chk({tag, "_im"}, out_im, 0);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            edge_cnt++;
            if (valid_out) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", valid_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_re", out_re, e.d.re);
                    chk("out_im", out_im, e.d.im);
                    chk("sop", sop_out, e.sop);
                    chk("eop", eop_out, e.eop);
                    if (e.sop && lat_q.size() != 0) chk("latency", edge_cnt - lat_q.pop_front(), 2);
                    in_burst = !e.eop;
                end
            end else begin
                run = 0;
                if (in_burst) begin
                    chk("burst_gap", valid_out, 1);
                    in_burst = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        max_run = 0;
        send_frame(0, 0, 0, N);
        stop();
        wait_drain("single_drain");
        chk("single_run", max_run, 16);

        max_run = 0;
        send_frame(0, 0, 2, N);
        stop();
        wait_drain("gapped_drain");
        chk("gapped_run", max_run, 16);

        max_run = 0;
        for (int f = 0; f < 4; f++) send_frame(0, 100 * f, 0, N);
        stop();
        wait_drain("b2b_drain");
        chk("b2b_run", max_run, 64);

        send_frame(0, 500, 0, 7);
        stop();
        do_reset("rst_in");
        send_frame(0, 200, 0, N);
        stop();
        wait_drain("rst_in_drain");

        // Output index 5 is on the pins at the seventh falling edge after stop.
        send_frame(0, 300, 0, N);
        stop();
        repeat (7) @(negedge clk);
        chk("pre_rst_burst_re", out_re, 300 + 5);
        do_reset("rst_burst");
        repeat (20) @(negedge clk);
        send_frame(0, 400, 1, N);
        stop();
        wait_drain("rst_burst_drain");

        send_frame(1, 0, 0, N);
        send_frame(1, 0, 0, N);
        stop();
        wait_drain("extreme_drain");

        for (int f = 0; f < 4; f++) send_frame(2, 0, -1, N);
        stop();
        wait_drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
